// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if -- request/acknowledge bundle between the interrupt controller and its
// environment (external IRQ source, pipeline status and fetch control unit).
//   irq_in      external interrupt request, active high, asynchronous to clk
//   int_en      global interrupt enable; 0 blocks new intr assertion
//   stall_in    pipeline stall; 1 = not a safe point
//   fetch_busy  fetch unit in FETCH2/WAIT/BRANCH; 1 = not a safe point
//   int_clr     acknowledge from fetch control, high while it loads PC from M[1]
//   rti_retire  one-cycle pulse when an RTI loads PC
//   intr        interrupt request to fetch control
//   in_service  an ISR is executing
//   irq_pending an edge is latched and not yet delivered
//   lost_cnt    saturating count of dropped interrupt edges
//   state_o     controller state (0 IDLE, 1 ARM, 2 REQ, 3 ISR)
// Modports: master = environment side, slave = controller side.
interface intr_ctrl_if;
  logic       irq_in;
  logic       int_en;
  logic       stall_in;
  logic       fetch_busy;
  logic       int_clr;
  logic       rti_retire;
  logic       intr;
  logic       in_service;
  logic       irq_pending;
  logic [7:0] lost_cnt;
  logic [1:0] state_o;

  modport master (
    output irq_in, int_en, stall_in, fetch_busy, int_clr, rti_retire,
    input  intr, in_service, irq_pending, lost_cnt, state_o
  );

  modport slave (
    input  irq_in, int_en, stall_in, fetch_busy, int_clr, rti_retire,
    output intr, in_service, irq_pending, lost_cnt, state_o
  );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl -- single-source interrupt controller. Detects rising edges on irq_in, holds a
// pending request until the pipeline reaches a safe point, raises intr until fetch control
// acknowledges with int_clr, then tracks the ISR until rti_retire. One further edge can be
// queued while a request is outstanding; extra edges are counted in lost_cnt (saturating).
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-low
//   bus    intr_ctrl_if.slave (see interface for signal list)
// Build option: define INTR_CTRL_SYNC_EN to pass irq_in through a 2-flop synchronizer,
// which adds two cycles to every irq_in-to-intr latency. Undefined: irq_in used directly.
module intr_ctrl (
  input logic        clk,
  input logic        reset,
  intr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StReq  = 2'd2,
    StIsr  = 2'd3
  } state_e;

  state_e     state_q;
  logic       irq_q;
  logic       pending_q;
  logic       intr_q;
  logic       in_service_q;
  logic [7:0] lost_q;

  logic irq_s;
  logic irq_edge;
  logic safe_point;
  logic lost_inc;

`ifdef INTR_CTRL_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = bus.irq_in;
`endif

  assign irq_edge   = irq_s & ~irq_q;
  assign safe_point = bus.int_en & ~bus.stall_in & ~bus.fetch_busy;

  // An edge is dropped when one is already queued. Leaving ARM for REQ delivers the queued
  // one, so a simultaneous edge takes its place instead of being lost.
  always_comb begin
    lost_inc = 1'b0;
    if (irq_edge && pending_q && (state_q != StIdle)) begin
      lost_inc = !((state_q == StArm) && safe_point);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      irq_q        <= 1'b0;
      pending_q    <= 1'b0;
      intr_q       <= 1'b0;
      in_service_q <= 1'b0;
      lost_q       <= 8'd0;
    end else begin
      irq_q <= irq_s;
      if (lost_inc && (lost_q != 8'hff)) begin
        lost_q <= lost_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (irq_edge) begin
            state_q   <= StArm;
            pending_q <= 1'b1;
          end
        end
        StArm: begin
          if (safe_point) begin
            state_q   <= StReq;
            intr_q    <= 1'b1;
            pending_q <= irq_edge;
          end
        end
        StReq: begin
          if (irq_edge && !pending_q) begin
            pending_q <= 1'b1;
          end
          if (bus.int_clr) begin
            state_q      <= StIsr;
            intr_q       <= 1'b0;
            in_service_q <= 1'b1;
          end
        end
        StIsr: begin
          if (irq_edge && !pending_q) begin
            pending_q <= 1'b1;
          end
          if (bus.rti_retire) begin
            in_service_q <= 1'b0;
            // A same-cycle edge counts as pending before the return decision.
            state_q      <= (pending_q || irq_edge) ? StArm : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.intr        = intr_q;
  assign bus.in_service  = in_service_q;
  assign bus.irq_pending = pending_q;
  assign bus.lost_cnt    = lost_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl -- directed self-checking bench for intr_ctrl. Cycle c means the interval
// just after rising edge c (counted from reset release); inputs driven there are sampled
// at edge c+1.
module tb_intr_ctrl;

`ifdef INTR_CTRL_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  intr_ctrl_if bus ();

  intr_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut(input logic irq);
    bus.irq_in     = irq;
    bus.int_en     = 1'b1;
    bus.stall_in   = 1'b0;
    bus.fetch_busy = 1'b0;
    bus.int_clr    = 1'b0;
    bus.rti_retire = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic pulse_irq();
    bus.irq_in = 1'b1;
    step();
    bus.irq_in = 1'b0;
    step();
  endtask

  // Raise an edge, wait (bounded) for REQ, acknowledge, and land in ISR.
  task automatic goto_isr();
    bit seen = 0;
    bus.irq_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.state_o == 2'd2) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL goto_isr_req: state=%0d, REQ never reached", bus.state_o);
    end
    bus.irq_in  = 1'b0;
    bus.int_clr = 1'b1;
    step();
    bus.int_clr = 1'b0;
    checks++;
    if (bus.state_o !== 2'd3) begin
      errors++;
      $display("FAIL goto_isr_state: got %0d want 3", bus.state_o);
    end
  endtask

  task automatic test_reset();
    bus.irq_in = 1'b1;
    reset = 1'b0;
    #3;
    checks++;
    if ({bus.intr, bus.in_service, bus.irq_pending, bus.lost_cnt, bus.state_o} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: intr=%b svc=%b pend=%b lost=%0d st=%0d want all 0",
               bus.intr, bus.in_service, bus.irq_pending, bus.lost_cnt, bus.state_o);
    end
    // irq_in already high at release must be seen as an edge on the first sample.
    reset_dut(1'b1);
    for (int i = 0; i < SyncLat; i++) step();
    step();
    checks++;
    if (bus.state_o !== 2'd1 || bus.irq_pending !== 1'b1) begin
      errors++;
      $display("FAIL reset_high_irq: st=%0d pend=%b want st=1 pend=1",
               bus.state_o, bus.irq_pending);
    end
  endtask

  task automatic test_delivery();
    logic [1:0] exp_st;
    reset_dut(1'b0);
    while (cyc < 5) step();
    for (int c = 5; c <= 22; c++) begin
      if (c < 6 + SyncLat) exp_st = 2'd0;
      else if (c == 6 + SyncLat) exp_st = 2'd1;
      else if (c <= 8 + SyncLat) exp_st = 2'd2;
      else if (c <= 20) exp_st = 2'd3;
      else exp_st = 2'd0;
      checks++;
      if (bus.state_o !== exp_st || bus.intr !== (exp_st == 2'd2) ||
          bus.in_service !== (exp_st == 2'd3)) begin
        errors++;
        $display("FAIL delivery_c%0d: st=%0d intr=%b svc=%b want st=%0d", c,
                 bus.state_o, bus.intr, bus.in_service, exp_st);
      end
      bus.irq_in     = 1'b1;
      bus.int_clr    = (c == 8 + SyncLat);
      bus.rti_retire = (c == 20);
      step();
    end
    checks++;
    if (bus.lost_cnt !== 8'd0 || bus.irq_pending !== 1'b0) begin
      errors++;
      $display("FAIL delivery_end: lost=%0d pend=%b want 0 0", bus.lost_cnt, bus.irq_pending);
    end
    // A held level does not re-trigger; a low cycle followed by high does.
    bus.irq_in = 1'b0;
    step();
    bus.irq_in = 1'b1;
    for (int i = 0; i < SyncLat + 1; i++) step();
    checks++;
    if (bus.state_o !== 2'd1) begin
      errors++;
      $display("FAIL retrigger: st=%0d want 1", bus.state_o);
    end
  endtask

  task automatic test_safe_point();
    reset_dut(1'b0);
    bus.fetch_busy = 1'b1;
    bus.irq_in     = 1'b1;
    for (int i = 0; i < SyncLat + 1; i++) step();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.state_o !== 2'd1 || bus.intr !== 1'b0) begin
        errors++;
        $display("FAIL safe_hold_%0d: st=%0d intr=%b want st=1 intr=0", i,
                 bus.state_o, bus.intr);
      end
    end
    bus.fetch_busy = 1'b0;
    step();
    checks++;
    if (bus.state_o !== 2'd2 || bus.intr !== 1'b1) begin
      errors++;
      $display("FAIL safe_release: st=%0d intr=%b want st=2 intr=1", bus.state_o, bus.intr);
    end
  endtask

  task automatic test_int_en();
    reset_dut(1'b0);
    bus.int_en = 1'b0;
    pulse_irq();
    for (int i = 0; i < 30; i++) begin
      step();
      if (i % 10 == 9) begin
        checks++;
        if (bus.state_o !== 2'd1 || bus.intr !== 1'b0) begin
          errors++;
          $display("FAIL int_en_hold_%0d: st=%0d intr=%b want st=1 intr=0", i,
                   bus.state_o, bus.intr);
        end
      end
    end
    bus.int_en   = 1'b1;
    bus.stall_in = 1'b1;
    step();
    step();
    checks++;
    if (bus.state_o !== 2'd1) begin
      errors++;
      $display("FAIL stall_hold: st=%0d want 1", bus.state_o);
    end
    bus.stall_in = 1'b0;
    step();
    checks++;
    if (bus.intr !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: intr=%b want 1", bus.intr);
    end
  endtask

  task automatic test_queue_lost();
    reset_dut(1'b0);
    goto_isr();
    for (int i = 0; i < 3; i++) pulse_irq();
    for (int i = 0; i < SyncLat; i++) step();
    checks++;
    if (bus.irq_pending !== 1'b1 || bus.lost_cnt !== 8'd2 || bus.state_o !== 2'd3) begin
      errors++;
      $display("FAIL queue_lost: pend=%b lost=%0d st=%0d want 1 2 3",
               bus.irq_pending, bus.lost_cnt, bus.state_o);
    end
    bus.rti_retire = 1'b1;
    step();
    bus.rti_retire = 1'b0;
    checks++;
    if (bus.state_o !== 2'd1 || bus.in_service !== 1'b0) begin
      errors++;
      $display("FAIL queue_rti: st=%0d svc=%b want 1 0", bus.state_o, bus.in_service);
    end
    step();
    checks++;
    if (bus.state_o !== 2'd2 || bus.intr !== 1'b1 || bus.irq_pending !== 1'b0) begin
      errors++;
      $display("FAIL queue_req: st=%0d intr=%b pend=%b want 2 1 0",
               bus.state_o, bus.intr, bus.irq_pending);
    end
  endtask

  task automatic test_edge_rti();
    reset_dut(1'b0);
    goto_isr();
    bus.irq_in = 1'b1;
    for (int i = 0; i < SyncLat; i++) step();
    bus.rti_retire = 1'b1;
    step();
    bus.rti_retire = 1'b0;
    bus.irq_in     = 1'b0;
    checks++;
    if (bus.state_o !== 2'd1 || bus.irq_pending !== 1'b1 || bus.lost_cnt !== 8'd0) begin
      errors++;
      $display("FAIL edge_rti: st=%0d pend=%b lost=%0d want 1 1 0",
               bus.state_o, bus.irq_pending, bus.lost_cnt);
    end
  endtask

  task automatic test_saturation();
    reset_dut(1'b0);
    goto_isr();
    pulse_irq();
    for (int i = 0; i < 254; i++) pulse_irq();
    for (int i = 0; i < SyncLat; i++) step();
    checks++;
    if (bus.lost_cnt !== 8'd254 || bus.irq_pending !== 1'b1) begin
      errors++;
      $display("FAIL sat_254: lost=%0d pend=%b want 254 1", bus.lost_cnt, bus.irq_pending);
    end
    pulse_irq();
    for (int i = 0; i < SyncLat; i++) step();
    checks++;
    if (bus.lost_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_255: lost=%0d want 255", bus.lost_cnt);
    end
    for (int i = 0; i < 45; i++) pulse_irq();
    for (int i = 0; i < SyncLat; i++) step();
    checks++;
    if (bus.lost_cnt !== 8'd255 || bus.state_o !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold: lost=%0d st=%0d want 255 3", bus.lost_cnt, bus.state_o);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut(1'b0);
    goto_isr();
    pulse_irq();
    pulse_irq();
    for (int i = 0; i < SyncLat; i++) step();
    bus.rti_retire = 1'b1;
    step();
    bus.rti_retire = 1'b0;
    step();
    pulse_irq();
    for (int i = 0; i < SyncLat; i++) step();
    checks++;
    if (bus.state_o !== 2'd2 || bus.intr !== 1'b1 || bus.lost_cnt !== 8'd1 ||
        bus.irq_pending !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: st=%0d intr=%b lost=%0d pend=%b want 2 1 1 1",
               bus.state_o, bus.intr, bus.lost_cnt, bus.irq_pending);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.intr, bus.in_service, bus.irq_pending, bus.lost_cnt, bus.state_o} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset: intr=%b svc=%b pend=%b lost=%0d st=%0d want all 0",
               bus.intr, bus.in_service, bus.irq_pending, bus.lost_cnt, bus.state_o);
    end
    reset = 1'b1;
  endtask

  initial begin
    bus.irq_in     = 1'b0;
    bus.int_en     = 1'b0;
    bus.stall_in   = 1'b0;
    bus.fetch_busy = 1'b0;
    bus.int_clr    = 1'b0;
    bus.rti_retire = 1'b0;
    test_reset();
    test_delivery();
    test_safe_point();
    test_int_en();
    test_queue_lost();
    test_edge_rti();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
